// File: rtl/reversi_pkg.sv
// Shared definitions for the Reversi move-resolution engine.
//   - Cell codes (EMPTY/BLACK/WHITE; 2'b11 is never written)
//   - Direction deltas, scanned in order E, NE, N, NW, W, SW, S, SE
//   - Initial board image, cell (x,y) at bits [2*(8y+x) +: 2]
//   - Engine state enum
package reversi_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  // White on (3,3) and (4,4); black on (4,3) and (3,4).
  localparam logic [127:0] INIT_BOARD = 128'h0000_0000_0000_0240_0180_0000_0000_0000;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } dirDelta_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWalk,
    StFlip,
    StDone,
    StReject
  } engineState_t;

  // Row 0 is the top, so "north" is dy = -1.
  function automatic dirDelta_t dirDelta(input logic [2:0] dir);
    dirDelta_t d;
    unique case (dir)
      3'd0: d = '{dx: 2'sb01, dy: 2'sb00};  // E
      3'd1: d = '{dx: 2'sb01, dy: 2'sb11};  // NE
      3'd2: d = '{dx: 2'sb00, dy: 2'sb11};  // N
      3'd3: d = '{dx: 2'sb11, dy: 2'sb11};  // NW
      3'd4: d = '{dx: 2'sb11, dy: 2'sb00};  // W
      3'd5: d = '{dx: 2'sb11, dy: 2'sb01};  // SW
      3'd6: d = '{dx: 2'sb00, dy: 2'sb01};  // S
      default: d = '{dx: 2'sb01, dy: 2'sb01};  // SE
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dir_step.sv
// Combinational one-cell step along a scan direction.
//   x, y     : current coordinate (0..7)
//   dir      : direction index 0..7
//   nx, ny   : coordinate one step along dir (meaningless when offBoard)
//   offBoard : step left the board (carry out of 7 or borrow below 0)
module dir_step
  import reversi_pkg::*;
(
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic [2:0] dir,
  output logic [2:0] nx,
  output logic [2:0] ny,
  output logic       offBoard
);

  dirDelta_t  delta;
  logic [3:0] sumX;
  logic [3:0] sumY;

  // Adding the sign-extended delta in 4 bits: bit 3 is set exactly on 7+1 (carry)
  // or 0-1 (borrow), so coordinates never silently wrap.
  always_comb begin
    delta    = dirDelta(dir);
    sumX     = {1'b0, x} + {{2{delta.dx[1]}}, delta.dx};
    sumY     = {1'b0, y} + {{2{delta.dy[1]}}, delta.dy};
    nx       = sumX[2:0];
    ny       = sumY[2:0];
    offBoard = sumX[3] | sumY[3];
  end

endmodule

// File: rtl/flip_engine.sv
// Reversi move resolution: owns the 8x8 board, validates one placement for the
// side to move, flips every bracketed run (one cell per cycle) and places the piece.
//   clk, resetn        : clock; asynchronous reset, active HIGH despite the name
//   player             : side to move (0 black, 1 white), latched on accept
//   move_valid/x/y     : placement request, taken only while ready
//   ready              : engine idle
//   next_turn          : pulse, legal move fully written (same cycle as last wr_en)
//   illegal            : pulse, move rejected, board untouched
//   wr_en/x/y/color    : one strobe per written cell
//   flip_count         : flips made by the last accepted move
//   board              : cell (x,y) at bits [2*(8y+x) +: 2]
module flip_engine
  import reversi_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         player,
  input  logic         move_valid,
  input  logic [2:0]   move_x,
  input  logic [2:0]   move_y,
  output logic         ready,
  output logic         next_turn,
  output logic         illegal,
  output logic         wr_en,
  output logic [2:0]   wr_x,
  output logic [2:0]   wr_y,
  output logic [1:0]   wr_color,
  output logic [5:0]   flip_count,
  output logic [127:0] board
);

  engineState_t stateQ, stateD;
  logic [2:0]   moveXQ, moveXD;
  logic [2:0]   moveYQ, moveYD;
  logic         playerQ, playerD;
  logic [2:0]   dirQ, dirD;
  logic [2:0]   ptrXQ, ptrXD;
  logic [2:0]   ptrYQ, ptrYD;
  logic         ptrOffQ, ptrOffD;
  logic [2:0]   runQ, runD;
  logic [5:0]   flipCountQ, flipCountD;
  logic [127:0] boardQ;

  logic [1:0] ownColor;
  logic [1:0] oppColor;
  logic [1:0] ptrCell;
  logic [1:0] moveCell;
  logic       ptrIsOpp;
  logic       ptrIsOwn;
  logic       nextDir;
  logic       stepFromMove;
  logic [2:0] stepDir;
  logic [2:0] stepX;
  logic [2:0] stepY;
  logic [2:0] stepNx;
  logic [2:0] stepNy;
  logic       stepOff;

  // Single stepper: advances the walk pointer, or restarts a ray from the move cell.
  dir_step uStep (
    .x        (stepX),
    .y        (stepY),
    .dir      (stepDir),
    .nx       (stepNx),
    .ny       (stepNy),
    .offBoard (stepOff)
  );

  // Decision logic. Depends only on registered state so the stepper input mux
  // never loops back through the stepper output.
  always_comb begin
    ownColor     = {playerQ, ~playerQ};
    oppColor     = {~playerQ, playerQ};
    ptrCell      = boardQ[{ptrYQ, ptrXQ, 1'b0} +: 2];
    moveCell     = boardQ[{moveYQ, moveXQ, 1'b0} +: 2];
    ptrIsOpp     = !ptrOffQ && (ptrCell == oppColor);
    ptrIsOwn     = !ptrOffQ && (ptrCell == ownColor);
    nextDir      = 1'b0;
    stepFromMove = 1'b0;
    stepDir      = dirQ;
    case (stateQ)
      StCheck: begin
        stepFromMove = 1'b1;
        stepDir      = 3'd0;
      end
      StWalk: begin
        if (!ptrIsOpp) begin
          if (ptrIsOwn && (runQ != 3'd0)) begin
            stepFromMove = 1'b1;  // bracketed: flip again from the cell next to the move
          end else begin
            nextDir = 1'b1;
          end
        end
      end
      StFlip: begin
        if (runQ == 3'd1) begin
          nextDir = 1'b1;
        end
      end
      default: ;
    endcase
    if (nextDir) begin
      stepFromMove = 1'b1;
      stepDir      = dirQ + 3'd1;  // wraps to 0 at dir 7, result unused then
    end
    stepX = stepFromMove ? moveXQ : ptrXQ;
    stepY = stepFromMove ? moveYQ : ptrYQ;
  end

  // Next state and write strobes.
  always_comb begin
    stateD     = stateQ;
    moveXD     = moveXQ;
    moveYD     = moveYQ;
    playerD    = playerQ;
    dirD       = dirQ;
    ptrXD      = ptrXQ;
    ptrYD      = ptrYQ;
    ptrOffD    = ptrOffQ;
    runD       = runQ;
    flipCountD = flipCountQ;
    wr_en      = 1'b0;
    wr_x       = 3'd0;
    wr_y       = 3'd0;
    wr_color   = 2'b00;

    case (stateQ)
      StIdle: begin
        if (move_valid) begin
          moveXD     = move_x;
          moveYD     = move_y;
          playerD    = player;
          flipCountD = 6'd0;
          stateD     = StCheck;
        end
      end
      StCheck: begin
        if (moveCell != EMPTY) begin
          stateD = StReject;
        end else begin
          dirD    = 3'd0;
          ptrXD   = stepNx;
          ptrYD   = stepNy;
          ptrOffD = stepOff;
          runD    = 3'd0;
          stateD  = StWalk;
        end
      end
      StWalk: begin
        if (ptrIsOpp) begin
          runD    = runQ + 3'd1;
          ptrXD   = stepNx;
          ptrYD   = stepNy;
          ptrOffD = stepOff;
        end else if (ptrIsOwn && (runQ != 3'd0)) begin
          ptrXD   = stepNx;
          ptrYD   = stepNy;
          ptrOffD = stepOff;
          stateD  = StFlip;
        end
      end
      StFlip: begin
        wr_en      = 1'b1;
        wr_x       = ptrXQ;
        wr_y       = ptrYQ;
        wr_color   = ownColor;
        flipCountD = flipCountQ + 6'd1;
        runD       = runQ - 3'd1;
        if (runQ != 3'd1) begin
          ptrXD   = stepNx;
          ptrYD   = stepNy;
          ptrOffD = stepOff;
        end
      end
      StDone: begin
        wr_en    = 1'b1;
        wr_x     = moveXQ;
        wr_y     = moveYQ;
        wr_color = ownColor;
        stateD   = StIdle;
      end
      StReject: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase

    // Ray finished: start the next direction or conclude the move.
    if (nextDir) begin
      if (dirQ != 3'd7) begin
        dirD    = dirQ + 3'd1;
        ptrXD   = stepNx;
        ptrYD   = stepNy;
        ptrOffD = stepOff;
        runD    = 3'd0;
        stateD  = StWalk;
      end else begin
        stateD = (flipCountD != 6'd0) ? StDone : StReject;
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stateQ     <= StIdle;
      moveXQ     <= 3'd0;
      moveYQ     <= 3'd0;
      playerQ    <= 1'b0;
      dirQ       <= 3'd0;
      ptrXQ      <= 3'd0;
      ptrYQ      <= 3'd0;
      ptrOffQ    <= 1'b0;
      runQ       <= 3'd0;
      flipCountQ <= 6'd0;
      boardQ     <= INIT_BOARD;
    end else begin
      stateQ     <= stateD;
      moveXQ     <= moveXD;
      moveYQ     <= moveYD;
      playerQ    <= playerD;
      dirQ       <= dirD;
      ptrXQ      <= ptrXD;
      ptrYQ      <= ptrYD;
      ptrOffQ    <= ptrOffD;
      runQ       <= runD;
      flipCountQ <= flipCountD;
      if (wr_en) begin
        boardQ[{wr_y, wr_x, 1'b0} +: 2] <= wr_color;
      end
    end
  end

  always_comb begin
    ready      = (stateQ == StIdle);
    next_turn  = (stateQ == StDone);
    illegal    = (stateQ == StReject);
    flip_count = flipCountQ;
    board      = boardQ;
  end

endmodule

// File: tb/tb_flip_engine.sv
module tb_flip_engine;

  logic         clk = 1'b0;
  logic         resetn;
  logic         player;
  logic         move_valid;
  logic [2:0]   move_x;
  logic [2:0]   move_y;
  logic         ready;
  logic         next_turn;
  logic         illegal;
  logic         wr_en;
  logic [2:0]   wr_x;
  logic [2:0]   wr_y;
  logic [1:0]   wr_color;
  logic [5:0]   flip_count;
  logic [127:0] board;

  always #5 clk = ~clk;

  flip_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .player     (player),
    .move_valid (move_valid),
    .move_x     (move_x),
    .move_y     (move_y),
    .ready      (ready),
    .next_turn  (next_turn),
    .illegal    (illegal),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .flip_count (flip_count),
    .board      (board)
  );

  // kind: 0 = cell write, 1 = next_turn, 2 = illegal
  typedef struct {
    int kind;
    int x;
    int y;
    int color;
  } ev_t;

  int   total = 0;
  int   bad = 0;
  ev_t  expQ[$];
  bit   monEn = 1'b1;
  int   spurNext = 0;
  int   mb[8][8];  // reference board [y][x]: 0 empty, 1 black, 2 white
  int   dxT[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int   dyT[8] = '{0, -1, -1, -1, 0, 1, 1, 1};
  int   seqP[$];
  int   seqX[$];
  int   seqY[$];

  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkBoard(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void initModel();
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) mb[y][x] = 0;
    mb[3][3] = 2;
    mb[4][4] = 2;
    mb[3][4] = 1;
    mb[4][3] = 1;
  endfunction

  function automatic logic [127:0] modelBoard();
    logic [127:0] b;
    b = '0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) b[2*(8*y+x) +: 2] = 2'(mb[y][x]);
    return b;
  endfunction

  // Flips bracketed along direction d; walk = cells examined along that ray.
  function automatic int runLen(input int p, input int x, input int y, input int d,
                                output int walk);
    int cx, cy, c;
    walk = 0;
    for (int k = 1; k < 9; k++) begin
      cx = x + k * dxT[d];
      cy = y + k * dyT[d];
      walk++;
      if (cx < 0 || cx > 7 || cy < 0 || cy > 7) return 0;
      c = mb[cy][cx];
      if (c != 2 - p) return (c == p + 1) ? k - 1 : 0;
    end
    return 0;
  endfunction

  function automatic int totalFlips(input int p, input int x, input int y);
    int s, w;
    s = 0;
    if (mb[y][x] != 0) return 0;
    for (int d = 0; d < 8; d++) s += runLen(p, x, y, d, w);
    return s;
  endfunction

  function automatic void applyModel(input int p, input int x, input int y);
    int r[8];
    int w;
    for (int d = 0; d < 8; d++) r[d] = runLen(p, x, y, d, w);
    for (int d = 0; d < 8; d++)
      for (int k = 1; k <= r[d]; k++) mb[y + k*dyT[d]][x + k*dxT[d]] = p + 1;
    mb[y][x] = p + 1;
  endfunction

  function automatic int pickLegal(input int p, output int lx, output int ly);
    int qx[$];
    int qy[$];
    int i;
    lx = 0;
    ly = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (totalFlips(p, x, y) > 0) begin
          qx.push_back(x);
          qy.push_back(y);
        end
    if (qx.size() == 0) return 0;
    i = int'($urandom_range(qx.size() - 1, 0));
    lx = qx[i];
    ly = qy[i];
    return qx.size();
  endfunction

  // Model-only random play until white at (7,0) would flip along both W and S.
  function automatic bit searchCorner();
    int p, lx, ly, w, n;
    for (int g = 0; g < 3000; g++) begin
      initModel();
      seqP.delete();
      seqX.delete();
      seqY.delete();
      for (int m = 0; m < 60; m++) begin
        if (mb[0][7] == 0 && runLen(1, 7, 0, 4, w) > 0 && runLen(1, 7, 0, 6, w) > 0)
          return 1'b1;
        p = int'($urandom_range(1, 0));
        n = pickLegal(p, lx, ly);
        if (n == 0) begin
          p = 1 - p;
          n = pickLegal(p, lx, ly);
        end
        if (n == 0) break;
        applyModel(p, lx, ly);
        seqP.push_back(p);
        seqX.push_back(lx);
        seqY.push_back(ly);
      end
    end
    return 1'b0;
  endfunction

  task automatic doMove(input int p, input int x, input int y, input bit hold);
    int  lat, n, flips, walkTot, w, r;
    bit  done;
    ev_t e;
    walkTot = 0;
    flips = 0;
    if (mb[y][x] != 0) begin
      lat = 2;
      e = '{kind: 2, x: 0, y: 0, color: 0};
      expQ.push_back(e);
    end else begin
      for (int d = 0; d < 8; d++) begin
        r = runLen(p, x, y, d, w);
        walkTot += w;
        for (int k = 1; k <= r; k++) begin
          e = '{kind: 0, x: x + k*dxT[d], y: y + k*dyT[d], color: p + 1};
          expQ.push_back(e);
        end
        flips += r;
      end
      lat = walkTot + flips + 2;
      if (flips > 0) begin
        e = '{kind: 0, x: x, y: y, color: p + 1};
        expQ.push_back(e);
        e = '{kind: 1, x: 0, y: 0, color: 0};
        expQ.push_back(e);
        applyModel(p, x, y);
      end else begin
        e = '{kind: 2, x: 0, y: 0, color: 0};
        expQ.push_back(e);
      end
    end

    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    player = 1'(p);
    move_x = 3'(x);
    move_y = 3'(y);
    move_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) move_valid = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (hold) begin
        player = 1'($urandom_range(1, 0));
        move_x = 3'($urandom_range(7, 0));
        move_y = 3'($urandom_range(7, 0));
      end
      if (next_turn || illegal || n >= 100) done = 1'b1;
    end
    move_valid = 1'b0;
    checkInt("move_latency", n, lat);
    @(negedge clk);
    checkBoard("board_after_move", board, modelBoard());
    checkInt("ready_after_move", int'(ready), 1);
    checkInt("flip_count", int'(flip_count), flips);
    checkInt("scoreboard_drained", expQ.size(), 0);
  endtask

  task automatic doReset();
    resetn = 1'b1;
    move_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    initModel();
    expQ.delete();
    @(negedge clk);
  endtask

  task automatic popCheck(input int kind, input int x, input int y, input int color);
    ev_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d (%0d,%0d) color=%0d, expected none",
               kind, x, y, color);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.x != x || e.y != y || e.color != color) begin
        bad++;
        $display("FAIL event_order: got kind=%0d (%0d,%0d) color=%0d, expected kind=%0d (%0d,%0d) color=%0d",
                 kind, x, y, color, e.kind, e.x, e.y, e.color);
      end
    end
  endtask

  // Monitor: every DUT-presented write/pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (!monEn) begin
      if (next_turn) spurNext++;
    end else begin
      if (wr_en) popCheck(0, int'(wr_x), int'(wr_y), int'(wr_color));
      if (next_turn) popCheck(1, 0, 0, 0);
      if (illegal) popCheck(2, 0, 0, 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p, lx, ly, n;
    bit  found;
    resetn = 1'b0;
    player = 1'b0;
    move_valid = 1'b0;
    move_x = 3'd0;
    move_y = 3'd0;
    #1 resetn = 1'b1;
    initModel();
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);

    checkBoard("reset_board", board, modelBoard());
    checkInt("reset_ready", int'(ready), 1);
    checkInt("reset_next_turn", int'(next_turn), 0);
    checkInt("reset_illegal", int'(illegal), 0);
    checkInt("reset_wr_en", int'(wr_en), 0);
    checkInt("reset_wr_xy", int'({wr_x, wr_y, wr_color}), 0);
    checkInt("reset_flip_count", int'(flip_count), 0);

    doMove(0, 2, 3, 1'b0);  // one flip at (3,3), then placement
    doMove(0, 0, 0, 1'b0);  // no bracket anywhere
    doMove(0, 3, 3, 1'b0);  // occupied: reject two cycles after accept

    repeat (30) begin
      p = int'($urandom_range(1, 0));
      if (pickLegal(p, lx, ly) == 0 || $urandom_range(3, 0) == 0) begin
        lx = int'($urandom_range(7, 0));
        ly = int'($urandom_range(7, 0));
      end
      doMove(p, lx, ly, 1'($urandom_range(1, 0)));
    end

    // Corner move bracketing along W and S; E/NE/N rays leave the board at once.
    doReset();
    found = searchCorner();
    initModel();
    if (!found) begin
      total++;
      bad++;
      $display("FAIL corner_search: got no position, expected one");
    end else begin
      for (int i = 0; i < seqP.size(); i++) doMove(seqP[i], seqX[i], seqY[i], 1'b0);
      doMove(1, 7, 0, 1'b0);
    end

    // Reset during FLIP with move_valid held high.
    doReset();
    monEn = 1'b0;
    spurNext = 0;
    player = 1'b0;
    move_x = 3'd2;
    move_y = 3'd3;
    move_valid = 1'b1;
    n = 0;
    while (!wr_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkInt("flip_reached", int'(wr_en), 1);
    resetn = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkBoard("board_after_midmove_reset", board, modelBoard());
    checkInt("ready_after_midmove_reset", int'(ready), 1);
    checkInt("flip_count_after_midmove_reset", int'(flip_count), 0);
    repeat (6) @(negedge clk);
    checkInt("next_turn_suppressed", spurNext, 0);
    monEn = 1'b1;
    doMove(0, 2, 3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
